// File: rtl/dsm_pkg.sv
// Shared DSM definitions: MASH word width, signed sample type and the
// CIC accumulator width helper used by the modulator and decimator.
package dsm_pkg;

    localparam int MASH_BW_DEF = 4;

    typedef logic signed [MASH_BW_DEF-1:0] mash_t;

    // Hogenauer register growth: ORDER * log2(R*M), with M = 1.
    function automatic int cic_acc_w(int mash_bw, int order, int decim);
        return mash_bw + order * $clog2(decim);
    endfunction

endpackage

// File: rtl/mash_cic_decimator_if.sv
// Stream bundle for the MASH CIC decimator.
// master drives in_valid/in_data and sinks out_valid/out_data; slave is the block.
interface mash_cic_decimator_if #(
    parameter int MASH_BW = 4,
    parameter int WIDTH   = 16
) ();

    logic                      in_valid;
    logic signed [MASH_BW-1:0] in_data;
    logic                      out_valid;
    logic signed [WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data
    );

endinterface

// File: rtl/cic_comb_stage.sv
// One registered CIC comb (differentiator, M = 1): y = x - x_prev.
// Ports: aclk, rst_n, clear, in_valid/in_data in, out_valid/out_data out.
module cic_comb_stage #(
    parameter int W = 16
) (
    input  logic                aclk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_data,
    output logic                out_valid,
    output logic signed [W-1:0] out_data
);

    logic signed [W-1:0] x_prev;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            x_prev    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data - x_prev;
                x_prev   <= in_data;
            end
        end
    end

endmodule

// File: rtl/mash_cic_decimator.sv
// MASH stream -> PCM: ORDER integrators, decimate by DECIM, ORDER combs.
// Ports: aclk, rst_n (async low), clear (sync flush), bus (slave stream).
module mash_cic_decimator
    import dsm_pkg::*;
#(
    parameter int MASH_BW = MASH_BW_DEF,
    parameter int WIDTH   = 16,
    parameter int ORDER   = 3,
    parameter int DECIM   = 16
) (
    input  logic                 aclk,
    input  logic                 rst_n,
    input  logic                 clear,
    mash_cic_decimator_if.slave  bus
);

    localparam int ACC_W = cic_acc_w(MASH_BW, ORDER, DECIM);
    localparam int CNT_W = $clog2(DECIM);

    typedef logic signed [ACC_W-1:0] acc_t;

    acc_t             integ [ORDER];
    acc_t             x_ext;
    logic [CNT_W-1:0] cnt;
    logic             tick;

    acc_t             comb_d [ORDER+1];
    logic             comb_v [ORDER+1];
    logic signed [WIDTH-1:0] scaled;

    assign x_ext = acc_t'(bus.in_data);
    assign tick  = bus.in_valid && !clear && (cnt == CNT_W'(DECIM - 1));

    // Integrators wrap freely; the combs cancel the modular overflow.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ORDER; i++) integ[i] <= '0;
            cnt <= '0;
        end else if (clear) begin
            for (int i = 0; i < ORDER; i++) integ[i] <= '0;
            cnt <= '0;
        end else if (bus.in_valid) begin
            integ[0] <= integ[0] + x_ext;
            for (int i = 1; i < ORDER; i++) integ[i] <= integ[i] + integ[i-1];
            cnt <= cnt + 1'b1;
        end
    end

    // Decimation point: last integrator sampled once per block.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            comb_v[0] <= 1'b0;
            comb_d[0] <= '0;
        end else if (clear) begin
            comb_v[0] <= 1'b0;
            comb_d[0] <= '0;
        end else begin
            comb_v[0] <= tick;
            if (tick) comb_d[0] <= integ[ORDER-1];
        end
    end

    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        cic_comb_stage #(.W(ACC_W)) u_comb (
            .aclk      (aclk),
            .rst_n     (rst_n),
            .clear     (clear),
            .in_valid  (comb_v[g]),
            .in_data   (comb_d[g]),
            .out_valid (comb_v[g+1]),
            .out_data  (comb_d[g+1])
        );
    end

    if (ACC_W >= WIDTH) begin : g_trunc
        assign scaled = comb_d[ORDER][ACC_W-1 -: WIDTH];
    end else begin : g_shift
        assign scaled = WIDTH'(comb_d[ORDER]) <<< (WIDTH - ACC_W);
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (clear) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            bus.out_valid <= comb_v[ORDER];
            if (comb_v[ORDER]) bus.out_data <= scaled;
        end
    end

endmodule

// File: tb/tb_mash_cic_decimator.sv
// Bench for mash_cic_decimator: vector table, corner sequences and
// random stimulus against a convolution reference model.
module tb_mash_cic_decimator;
    import dsm_pkg::*;

    localparam int MASH_BW = 4;
    localparam int WIDTH   = 16;
    localparam int ORDER   = 3;
    localparam int DECIM   = 16;
    localparam int LAT     = ORDER + 1;
    localparam int ACC_W   = cic_acc_w(MASH_BW, ORDER, DECIM);

    logic aclk  = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    mash_cic_decimator_if #(.MASH_BW(MASH_BW), .WIDTH(WIDTH)) bus ();

    mash_cic_decimator #(
        .MASH_BW (MASH_BW),
        .WIDTH   (WIDTH),
        .ORDER   (ORDER),
        .DECIM   (DECIM)
    ) dut (
        .aclk  (aclk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_out  = 0;
    int hist[$];
    int tick_q[$];
    int kern[$];
    int last_out = 0;

    typedef struct {
        int a;
        int b;
        int period;
        int expv;
    } vec_t;

    vec_t vecs[5];

    function automatic void check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     name, got, want, cyc);
        end
    endfunction

    // CIC impulse response: boxcar of length DECIM convolved ORDER times.
    function automatic void build_kernel();
        int tmp[$];
        kern.delete();
        kern.push_back(1);
        repeat (ORDER) begin
            tmp.delete();
            for (int i = 0; i < kern.size() + DECIM - 1; i++) tmp.push_back(0);
            for (int i = 0; i < kern.size(); i++)
                for (int j = 0; j < DECIM; j++) tmp[i+j] += kern[i];
            kern = tmp;
        end
    endfunction

    // Block b ends at accepted sample (b+1)*DECIM-1; the integrator cascade
    // adds one sample of delay per stage. Result is taken modulo 2^ACC_W.
    function automatic int model_out(int b);
        int k;
        int idx;
        int y;
        logic [31:0] yv;
        logic signed [WIDTH-1:0] r;
        k = (b + 1) * DECIM - 1;
        y = 0;
        for (int j = 0; j < kern.size(); j++) begin
            idx = k - ORDER - j;
            if (idx >= 0) y += kern[j] * hist[idx];
        end
        yv = y;
        r  = yv[ACC_W-1 -: WIDTH];
        return int'(r);
    endfunction

    function automatic void model_reset();
        hist.delete();
        tick_q.delete();
        n_out    = 0;
        last_out = 0;
    endfunction

    function automatic void sample();
        bit exp_v;
        exp_v = (tick_q.size() > 0) && (tick_q[0] == cyc - LAT);
        if (exp_v || bus.out_valid)
            check("out_valid_timing", int'(bus.out_valid), int'(exp_v));
        if (exp_v) void'(tick_q.pop_front());
        if (bus.out_valid) begin
            if (n_out >= ORDER)
                check("out_data_model", int'($signed(bus.out_data)), model_out(n_out));
            last_out = int'($signed(bus.out_data));
            n_out++;
        end else begin
            check("out_data_hold", int'($signed(bus.out_data)), last_out);
        end
    endfunction

    task automatic step(input bit v, input int d, input bit clr);
        bus.in_valid = v;
        bus.in_data  = MASH_BW'(d);
        clear        = clr;
        @(posedge aclk);
        cyc++;
        if (clr) begin
            model_reset();
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() % DECIM == 0) tick_q.push_back(cyc);
        end
        #1;
        sample();
    endtask

    task automatic pulse_reset();
        bus.in_valid = 1'b0;
        clear        = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_data", int'($signed(bus.out_data)), 0);
        @(posedge aclk);
        cyc++;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        repeat (LAT + 2) step(1'b0, 0, 1'b0);
    endtask

    task automatic run_blocks(input int nblk, input int a, input int b, input int period);
        int acc = 0;
        for (int i = 0; i < nblk * DECIM * period; i++) begin
            bit go;
            go = (i % period == 0);
            step(go, (acc % 2 == 0) ? a : b, 1'b0);
            if (go) acc++;
        end
        drain();
    endtask

    initial begin
        build_kernel();
        vecs[0] = '{a:  1, b:  1, period: 1, expv:  4096};
        vecs[1] = '{a: -1, b: -1, period: 1, expv: -4096};
        vecs[2] = '{a:  2, b:  2, period: 1, expv:  8192};
        vecs[3] = '{a:  2, b: -1, period: 1, expv:  2048};
        vecs[4] = '{a:  1, b:  1, period: 3, expv:  4096};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("por_out_valid", int'(bus.out_valid), 0);
        check("por_out_data", int'($signed(bus.out_data)), 0);
        #2;
        rst_n = 1'b1;

        // Idle after reset: nothing may come out.
        repeat (100) step(1'b0, 0, 1'b0);
        check("idle_pulses", n_out, 0);
        check("idle_out_data", int'($signed(bus.out_data)), 0);

        foreach (vecs[v]) begin
            step(1'b0, 0, 1'b1);
            run_blocks(7, vecs[v].a, vecs[v].b, vecs[v].period);
            check($sformatf("vec%0d_count", v), n_out, 7);
            check($sformatf("vec%0d_settled", v), int'($signed(bus.out_data)), vecs[v].expv);
        end

        // Clear together with in_valid part-way through a block.
        step(1'b0, 0, 1'b1);
        repeat (7) step(1'b1, 1, 1'b0);
        step(1'b1, 1, 1'b1);
        check("clear_flush_data", int'($signed(bus.out_data)), 0);
        run_blocks(6, 1, 1, 1);
        check("clear_count", n_out, 6);
        check("clear_settled", int'($signed(bus.out_data)), 4096);

        // Asynchronous reset part-way through a block.
        repeat (5) step(1'b1, 1, 1'b0);
        pulse_reset();
        run_blocks(6, 1, 1, 1);
        check("rst_count", n_out, 6);
        check("rst_settled", int'($signed(bus.out_data)), 4096);

        // Random data with random gaps.
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(3) != 0, int'($urandom_range(15)) - 8, 1'b0);
        drain();

        // Long constant run: integrators wrap many times.
        step(1'b0, 0, 1'b1);
        repeat (70000) step(1'b1, 2, 1'b0);
        drain();
        check("long_count", n_out, 70000 / DECIM);
        check("long_settled", int'($signed(bus.out_data)), 8192);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
